cla_nl_combine: RTL and testbench

CLA_NL_COMBINE -- requirements
Module: cla_nl_combine

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_group_or.sv | 13 +
 rtl/cla_nl_combine.sv | 112 +++++++++++
 tb/tb_cla_nl_combine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared term-group layout for the non-linear carry generator and combiner
package cla_pkg;

    function automatic int grp_sz(input int j);
        return (1 << (j + 2)) - 1;
    endfunction

    function automatic int grp_off(input int j);
        return (1 << (j + 2)) - 4 - j;
    endfunction

    function automatic int nnl_count(input int nbit);
        return (1 << (nbit + 2)) - 4 - nbit;
    endfunction

endpackage

// File: rtl/cla_group_or.sv
// rtl/cla_group_or.sv - OR-reduces one term group into the carry out of bit J
module cla_group_or
    import cla_pkg::*;
#(
    parameter int J = 0
) (
    input  logic [grp_sz(J)-1:0] n_slice,
    output logic                 carry
);

    assign carry = |n_slice;

endmodule

// File: rtl/cla_nl_combine.sv
// rtl/cla_nl_combine.sv - two-stage carry-lookahead combiner from product terms
// Optional reference-adder self-check enabled by defining CLA_SELFCHECK_EN.
module cla_nl_combine
    import cla_pkg::*;
#(
    parameter int NBIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NBIT-1:0]              a,
    input  logic [NBIT-1:0]              b,
    input  logic                         c,
    input  logic [nnl_count(NBIT)-1:0]   n,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NBIT-1:0]              s,
    output logic                         cout,
    output logic                         err
);

    localparam int NNL = nnl_count(NBIT);

    logic [NBIT:0]   carry;
    logic            s1_valid;
    logic [NBIT:0]   s1_carry;
    logic [NBIT-1:0] s1_a;
    logic [NBIT-1:0] s1_b;
    logic            s1_adv;
    logic            s2_adv;

    assign carry[0] = c;

    for (genvar j = 0; j < NBIT; j++) begin : g_grp
        cla_group_or #(.J(j)) u_or (
            .n_slice (n[grp_off(j) +: grp_sz(j)]),
            .carry   (carry[j+1])
        );
    end

    // A stage may load whenever its current content leaves or it holds nothing.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_carry <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_carry <= carry;
                s1_a     <= a;
                s1_b     <= b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s    <= s1_a ^ s1_b ^ s1_carry[NBIT-1:0];
                cout <= s1_carry[NBIT];
            end
        end
    end

`ifdef CLA_SELFCHECK_EN
    logic [NBIT:0] s1_ref;
    logic [NBIT:0] s2_ref;
    logic          err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_ref <= '0;
        end else if (s1_adv && in_valid) begin
            s1_ref <= {1'b0, a} + {1'b0, b} + {{NBIT{1'b0}}, c};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_ref <= '0;
        end else if (s2_adv && s1_valid) begin
            s2_ref <= s1_ref;
        end
    end

    // Judged only when a result is actually handed downstream; sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (out_valid && out_ready && (s2_ref != {cout, s})) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_nl_combine.sv
// tb/tb_cla_nl_combine.sv - directed self-checking bench for cla_nl_combine
module tb_cla_nl_combine;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        c;
    logic [55:0] n;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  s;
    logic        cout;
    logic        err;

`ifdef CLA_SELFCHECK_EN
    localparam logic EXP_ERR_FORCED = 1'b1;
`else
    localparam logic EXP_ERR_FORCED = 1'b0;
`endif

    int checks    = 0;
    int passed    = 0;
    int delivered = 0;
    int accepted  = 0;
    logic [4:0] exp_next;
    logic [4:0] exp_q[$];

    cla_nl_combine #(.NBIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Carry-lookahead product terms: term k of group j is p[j..j-k+1] & g[j-k], last term uses c.
    function automatic logic [55:0] gen_n(input logic [3:0] ga, input logic [3:0] gb, input logic gc);
        logic [55:0] r;
        logic [3:0]  g;
        logic [3:0]  p;
        logic        prod;
        int          off[4];
        off = '{0, 3, 10, 25};
        r = '0;
        g = ga & gb;
        p = ga ^ gb;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k <= j + 1; k++) begin
                prod = 1'b1;
                for (int i = j - k + 1; i <= j; i++) prod = prod & p[i];
                if (k <= j) prod = prod & g[j-k];
                else        prod = prod & gc;
                r[off[j]+k] = prod;
            end
        end
        return r;
    endfunction

    task automatic drive(input logic [3:0] va, input logic [3:0] vb, input logic vc, input logic [4:0] e);
        a        = va;
        b        = vb;
        c        = vc;
        n        = gen_n(va, vb, vc);
        exp_next = e;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        logic [4:0] e;
        #1;
        if (out_valid && out_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {27'd0, cout, s}, {27'd0, e});
            end
        end
        if (in_valid && in_ready) begin
            accepted++;
            exp_q.push_back(exp_next);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int a0;
        logic [8:0] vv;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = 1'b0; n = '0; exp_next = '0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {27'd0, cout, s}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // F + 1 + 0 = 0x10
        drive(4'hF, 4'h1, 1'b0, 5'h10);
        tick();
        in_valid = 1'b0;
        check("lat_one_cycle", {31'd0, out_valid}, 32'd0);
        tick();
        check("lat_two_valid", {31'd0, out_valid}, 32'd1);
        check("f_plus_1", {27'd0, cout, s}, 32'h10);
        tick();
        check("f_plus_1_drained", {31'd0, out_valid}, 32'd0);

        // 5 + A + 1 = 0x10
        drive(4'h5, 4'hA, 1'b1, 5'h10);
        tick();
        in_valid = 1'b0;
        tick();
        check("5_a_1", {27'd0, cout, s}, 32'h10);
        tick();
        check("5_a_1_err", {31'd0, err}, 32'd0);

        // Back-pressure: three beats against a stalled sink
        out_ready = 1'b0;
        drive(4'h1, 4'h2, 1'b0, 5'h03);
        tick();
        drive(4'h7, 4'h7, 1'b1, 5'h0F);
        tick();
        drive(4'hF, 4'hF, 1'b1, 5'h1F);
        #1;
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_stable", {27'd0, cout, s}, 32'h03);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) tick();
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Zeroed term vector: combiner yields 3^1 = 2, reference says 4
        drive(4'h3, 4'h1, 1'b0, 5'h02);
        n = '0;
        tick();
        in_valid = 1'b0;
        tick();
        check("forced_sum", {27'd0, cout, s}, 32'h02);
        tick();
        check("forced_err", {31'd0, err}, {31'd0, EXP_ERR_FORCED});
        tick();
        check("forced_err_sticky", {31'd0, err}, {31'd0, EXP_ERR_FORCED});

        // Reset with two beats in flight
        out_ready = 1'b0;
        drive(4'h2, 4'h2, 1'b0, 5'h04);
        tick();
        drive(4'h6, 4'h3, 1'b0, 5'h09);
        tick();
        in_valid = 1'b0;
        check("inflight_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 4; i++) tick();
        check("no_stale_result", 32'(delivered - d0), 32'd0);

        // Exhaustive stream at full rate
        d0 = delivered;
        a0 = accepted;
        for (int v = 0; v < 512; v++) begin
            vv = v[8:0];
            drive(vv[3:0], vv[7:4], vv[8], {1'b0, vv[3:0]} + {1'b0, vv[7:4]} + {4'd0, vv[8]});
            tick();
        end
        in_valid = 1'b0;
        check("stream_accepts", 32'(accepted - a0), 32'd512);
        check("stream_rate", 32'(delivered - d0), 32'd510);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
        check("stream_total", 32'(delivered - d0), 32'd512);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_err", {31'd0, err}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
